apb4_rr_arbiter: RTL and testbench
==================================

Name: apb4_rr_arbiter

Overview:
- Shares one APB4 completer bus between NUM_REQ independent requesters.
- Round-robin arbitration; each requester presents one transfer at a time over a valid/ready request channel.
- Sequences the granted transfer through the APB4 SETUP/ACCESS phases and returns read data and slave error on a per-requester response pulse.
- Sits between on-chip masters (DMA, debug bridge, CPU bridge) and the peripheral APB4 fabric.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- ADDR_WIDTH, 32, paddr width
- DATA_WIDTH, 32, pwdata/prdata width (multiple of 8)

Ports:
- pclk  input  1  bus clock
- presetn  input  1  asynchronous active-low reset
- req_valid_i  input  NUM_REQ  per-requester transfer request
- req_ready_o  output  NUM_REQ  one-hot; request accepted this cycle
- req_write_i  input  NUM_REQ  1 = write, 0 = read
- req_addr_i  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata_i  input  NUM_REQ*DATA_WIDTH  packed write data
- rsp_valid_o  output  NUM_REQ  one-hot; transfer of requester i completed
- rsp_rdata_o  output  DATA_WIDTH  shared read data, valid with rsp_valid_o
- rsp_err_o  output  1  pslverr of the completed transfer, valid with rsp_valid_o
- paddr  output  ADDR_WIDTH  APB4 address
- pprot  output  3  tied 3'b000
- psel  output  1  APB4 select
- penable  output  1  APB4 enable
- pwrite  output  1  APB4 direction
- pwdata  output  DATA_WIDTH  APB4 write data
- pstrb  output  DATA_WIDTH/8  all-ones when pwrite=1, zero otherwise
- pready  input  1  completer ready
- prdata  input  DATA_WIDTH  completer read data
- pslverr  input  1  completer error

Behaviour:
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, req_ready_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, FSM=IDLE, rr pointer last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
- FSM states:
  - IDLE: psel=0, penable=0.
  - SETUP: psel=1, penable=0; lasts exactly one cycle.
  - ACCESS: psel=1, penable=1; held until pready=1.
- Arbitration point: a cycle in IDLE, or the completing ACCESS cycle (pready=1).
  - Grant goes to the first asserted req_valid_i at index (last_grant+1) mod NUM_REQ, searching upward with wrap.
  - req_ready_o[grant] is asserted combinationally in that cycle.
  - At the clock edge: write/addr/wdata of the grantee are registered onto paddr/pwrite/pwdata, grant index is stored, last_grant is updated, and the FSM goes to SETUP.
- No request at an arbitration point: IDLE→IDLE, or ACCESS→IDLE.
- Back-to-back: a completion with a pending request goes ACCESS→SETUP directly, with no IDLE cycle.
- Completion: in ACCESS with pready=1:
  - rsp_valid_o[stored grant]=1, combinational, same cycle.
  - rsp_rdata_o=prdata when pwrite=0, zero for writes.
  - rsp_err_o=pslverr.
- Latency: req_valid_i in IDLE at cycle t → SETUP at t+1 → ACCESS at t+2 → rsp_valid_o at t+2 if no wait states, t+2+W with W wait cycles.
- Requester rules:
  - Hold valid and payload stable until ready.
  - A requester may re-assert in the completion cycle of its own transfer; it then competes normally and loses to other pending requesters.
- paddr/pwrite/pwdata hold their last value in IDLE; no 'x driven.
- Grantee payload changes after acceptance have no effect on the bus.
- Asynchronous reset assertion mid-transfer: all outputs go to reset values immediately, and the in-flight response is dropped (no rsp_valid_o).
- pslverr is ignored outside the completing ACCESS cycle.

Decomposition:
- Package apb4_arb_pkg:
  - State enum arb_state_e {IDLE, SETUP, ACCESS}.
  - Localparam helper for the grant index width, $clog2(NUM_REQ) with a minimum of 1.
- Sub-module rr_arb_core, parameterised on NUM_REQ:
  - Combinational round-robin grant from request vector and last_grant; outputs one-hot grant, grant index and any_grant.
  - last_grant register with update enable; asynchronous active-low reset.
- Top: FSM, payload registers, response muxing.

Test Plan:
- Single write: req0 write addr 0x1000_0010, data 0xDEAD_BEEF, pready tied 1 → psel at t+1, penable at t+2, pstrb=4'hF, rsp_valid_o=4'b0001 at t+2, rsp_err_o=0.
- Wait states with read: req2 read addr 0x20, pready low 3 ACCESS cycles, then prdata=0x1234_5678 → penable high 4 cycles, rsp_valid_o[2] only in the final cycle, rsp_rdata_o=0x1234_5678.
- Fairness: all four valid continuously from reset, 8 transfers, pready=1 → grant order 0,1,2,3,0,1,2,3; ACCESS→SETUP with no IDLE gap; each transfer 2 cycles.
- Rotation: last_grant=1, req0 and req3 valid → req3 granted first, then req0.
- Error: req1 write, pslverr=1 with pready → rsp_err_o=1 with rsp_valid_o[1]; next transfer shows rsp_err_o=0.
- Reset mid-ACCESS: presetn low while penable=1 → psel/penable 0 asynchronously, no rsp_valid_o; after release, req0 is top priority again.

Source files
------------

// File: rtl/apb4_arb_pkg.sv
// Shared types and helpers for the APB4 round-robin arbiter.
package apb4_arb_pkg;

    // Bus sequencing states; IDLE must stay at encoding 0 so the debug port reads 0 in reset.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

    // Width of a requester index; a single requester bit is still one bit wide.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_core.sv
// Round-robin grant selection with the last_grant pointer register.
// Search starts just above last_grant and wraps, so the most recent winner has lowest priority.
module rr_arb_core
    import apb4_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_update,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any_grant
);

    logic [IDX_W-1:0] r_last;
    logic             w_hi_hit;
    logic             w_lo_hit;
    logic [IDX_W-1:0] w_hi_idx;
    logic [IDX_W-1:0] w_lo_idx;

    // Two passes: lowest requester above last_grant, and lowest requester overall (the wrap case).
    always_comb begin
        w_hi_hit = 1'b0;
        w_hi_idx = '0;
        w_lo_hit = 1'b0;
        w_lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_lo_hit = 1'b1;
                w_lo_idx = IDX_W'(i);
                if (i > int'(r_last)) begin
                    w_hi_hit = 1'b1;
                    w_hi_idx = IDX_W'(i);
                end
            end
        end
    end

    // Prefer the above-pointer winner; fall back to the wrapped one.
    always_comb begin
        o_any_grant = w_hi_hit | w_lo_hit;
        o_grant_idx = w_hi_hit ? w_hi_idx : w_lo_idx;
        o_grant     = '0;
        if (o_any_grant) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

    // Pointer resets to the top index so requester 0 wins first after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= IDX_W'(NUM_REQ - 1);
        end else if (i_update) begin
            r_last <= o_grant_idx;
        end
    end

endmodule

// File: rtl/apb4_rr_arbiter.sv
// Shares one APB4 completer port between NUM_REQ requesters with round-robin arbitration.
// Request channel: a transfer is accepted in the cycle where req_valid_i[i] and req_ready_o[i]
// are both high; the requester holds valid and payload stable until then. req_ready_o depends
// combinationally on req_valid_i. The response is a single-cycle rsp_valid_o[i] pulse with
// rsp_rdata_o/rsp_err_o, raised in the completing ACCESS cycle.
module apb4_rr_arbiter
    import apb4_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          pclk,
    input  logic                          presetn,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0]            req_write_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic [2:0]                    pprot,
    output logic                          psel,
    output logic                          penable,
    output logic                          pwrite,
    output logic [DATA_WIDTH-1:0]         pwdata,
    output logic [DATA_WIDTH/8-1:0]       pstrb,
    input  logic                          pready,
    input  logic [DATA_WIDTH-1:0]         prdata,
    input  logic                          pslverr,
    output logic [1:0]                    o_dbg_state
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_e             r_state;
    arb_state_e             w_next_state;
    logic [ADDR_WIDTH-1:0]  r_paddr;
    logic                   r_pwrite;
    logic [DATA_WIDTH-1:0]  r_pwdata;
    logic [IDX_W-1:0]       r_gidx;

    logic [NUM_REQ-1:0]     w_grant;
    logic [IDX_W-1:0]       w_grant_idx;
    logic                   w_any_grant;
    logic                   w_done;
    logic                   w_arb_point;
    logic                   w_accept;

    rr_arb_core #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arb_core (
        .i_clk       (pclk),
        .i_rst_n     (presetn),
        .i_req       (req_valid_i),
        .i_update    (w_accept),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_any_grant)
    );

    // The bus is free for a new grant when idle or when the current ACCESS completes this cycle.
    // Reset gates acceptance so nothing is handshaken while presetn is low.
    always_comb begin
        w_done      = (r_state == ACCESS) && pready;
        w_arb_point = (r_state == IDLE) || w_done;
        w_accept    = presetn && w_arb_point && w_any_grant;
    end

    // Next state: a grant always leads to SETUP, which makes back-to-back transfers skip IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = SETUP;
                end
            end
            SETUP: begin
                w_next_state = ACCESS;
            end
            ACCESS: begin
                if (w_done) begin
                    w_next_state = w_accept ? SETUP : IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the grantee's payload at acceptance; it is held until the next grant, also in IDLE.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_gidx   <= '0;
        end else if (w_accept) begin
            r_paddr  <= req_addr_i[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            r_pwrite <= req_write_i[w_grant_idx];
            r_pwdata <= req_wdata_i[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
            r_gidx   <= w_grant_idx;
        end
    end

    // Handshake and response outputs; read data is zeroed for writes and outside completion.
    always_comb begin
        req_ready_o = w_accept ? w_grant : '0;
        rsp_valid_o = '0;
        if (w_done) begin
            rsp_valid_o[r_gidx] = 1'b1;
        end
        rsp_rdata_o = (w_done && !r_pwrite) ? prdata : '0;
        rsp_err_o   = w_done & pslverr;
    end

    assign psel        = (r_state != IDLE);
    assign penable     = (r_state == ACCESS);
    assign paddr       = r_paddr;
    assign pwrite      = r_pwrite;
    assign pwdata      = r_pwdata;
    assign pstrb       = {(DATA_WIDTH/8){r_pwrite}};
    assign pprot       = 3'b000;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb4_rr_arbiter.sv
// Bench for apb4_rr_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (pending set, rotating pointer, per-transfer wait count).
module tb_apb4_rr_arbiter;
    import apb4_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            pclk = 1'b0;
    logic            presetn = 1'b0;
    logic [N-1:0]    req_valid_i;
    logic [N-1:0]    req_ready_o;
    logic [N-1:0]    req_write_i;
    logic [N*AW-1:0] req_addr_i;
    logic [N*DW-1:0] req_wdata_i;
    logic [N-1:0]    rsp_valid_o;
    logic [DW-1:0]   rsp_rdata_o;
    logic            rsp_err_o;
    logic [AW-1:0]   paddr;
    logic [2:0]      pprot;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic [DW/8-1:0] pstrb;
    logic            pready;
    logic [DW-1:0]   prdata;
    logic            pslverr;
    logic [1:0]      o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    apb4_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .paddr       (paddr),
        .pprot       (pprot),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 pclk = ~pclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        req_valid_i = '0;
        req_write_i = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        pready      = 1'b0;
        prdata      = '0;
        pslverr     = 1'b0;
    endtask

    // Leaves the bench just after a rising edge with reset released (cycle 0, IDLE).
    task automatic do_reset();
        presetn = 1'b0;
        clear_inputs();
        repeat (3) @(posedge pclk);
        #1;
        presetn = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid_i[i]        = 1'b1;
        req_write_i[i]        = w;
        req_addr_i[i*AW +: AW] = a;
        req_wdata_i[i*DW +: DW] = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        presetn = 1'b0;
        clear_inputs();
        req_valid_i = 4'b1111;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        n_checks++; if ({psel, penable, pwrite} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {psel, penable, pwrite}); end
        n_checks++; if (paddr !== '0 || pwdata !== '0) begin n_fail++; $display("FAIL reset_payload: got %h/%h expected 0/0", paddr, pwdata); end
        n_checks++; if (req_ready_o !== 4'b0000 || rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL reset_handshake: got %b/%b expected 0000/0000", req_ready_o, rsp_valid_o); end
        n_checks++; if (rsp_err_o !== 1'b0 || rsp_rdata_o !== '0) begin n_fail++; $display("FAIL reset_rsp: got %b/%h expected 0/0", rsp_err_o, rsp_rdata_o); end
        n_checks++; if (o_dbg_state !== 2'd0 || pprot !== 3'b000) begin n_fail++; $display("FAIL reset_state: got %0d/%b expected 0/000", o_dbg_state, pprot); end
    endtask

    task automatic test_single_write();
        do_reset();
        pready = 1'b1;
        set_req(0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF);
        @(negedge pclk);
        n_checks++; if (req_ready_o !== 4'b0001 || psel !== 1'b0) begin n_fail++; $display("FAIL single_accept: got %b/%b expected 0001/0", req_ready_o, psel); end
        next_cycle();
        req_valid_i = '0;
        req_wdata_i = {N{32'h0BAD_0BAD}};
        @(negedge pclk);
        n_checks++; if ({psel, penable, pwrite} !== 3'b101 || pstrb !== 4'hF) begin n_fail++; $display("FAIL single_setup: got %b/%h expected 101/f", {psel, penable, pwrite}, pstrb); end
        n_checks++; if (paddr !== 32'h1000_0010 || pwdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_payload: got %h/%h expected 10000010/deadbeef", paddr, pwdata); end
        n_checks++; if (rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL single_early_rsp: got %b expected 0000", rsp_valid_o); end
        next_cycle();
        @(negedge pclk);
        n_checks++; if ({psel, penable} !== 2'b11 || rsp_valid_o !== 4'b0001) begin n_fail++; $display("FAIL single_access: got %b/%b expected 11/0001", {psel, penable}, rsp_valid_o); end
        n_checks++; if (rsp_err_o !== 1'b0 || rsp_rdata_o !== '0) begin n_fail++; $display("FAIL single_rsp: got %b/%h expected 0/0", rsp_err_o, rsp_rdata_o); end
        next_cycle();
        @(negedge pclk);
        n_checks++; if ({psel, penable} !== 2'b00 || pwdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_idle: got %b/%h expected 00/deadbeef", {psel, penable}, pwdata); end
    endtask

    task automatic test_wait_read();
        int pen_cnt;
        do_reset();
        pready  = 1'b0;
        pslverr = 1'b1;
        prdata  = 32'hBAD0_BAD0;
        pen_cnt = 0;
        set_req(2, 1'b0, 32'h0000_0020, 32'h0);
        @(negedge pclk);
        n_checks++; if (req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL wait_accept: got %b expected 0100", req_ready_o); end
        next_cycle();
        req_valid_i = '0;
        @(negedge pclk);
        n_checks++; if ({psel, penable, pwrite} !== 3'b100 || pstrb !== 4'h0 || paddr !== 32'h20) begin n_fail++; $display("FAIL wait_setup: got %b/%h/%h expected 100/0/20", {psel, penable, pwrite}, pstrb, paddr); end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge pclk);
            if (penable === 1'b1) pen_cnt++;
            n_checks++; if (rsp_valid_o !== 4'b0000 || rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL wait_hold_%0d: got %b/%b expected 0000/0", k, rsp_valid_o, rsp_err_o); end
        end
        next_cycle();
        pready  = 1'b1;
        pslverr = 1'b0;
        prdata  = 32'h1234_5678;
        @(negedge pclk);
        if (penable === 1'b1) pen_cnt++;
        n_checks++; if (rsp_valid_o !== 4'b0100 || rsp_rdata_o !== 32'h1234_5678 || rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL wait_done: got %b/%h/%b expected 0100/12345678/0", rsp_valid_o, rsp_rdata_o, rsp_err_o); end
        n_checks++; if (pen_cnt !== 4) begin n_fail++; $display("FAIL wait_penable_len: got %0d expected 4", pen_cnt); end
        next_cycle();
        pready = 1'b0;
        @(negedge pclk);
        n_checks++; if (psel !== 1'b0 || rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL wait_idle: got %b/%b expected 0/0000", psel, rsp_valid_o); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] exp_v;
        int exp_q[$];
        int rsp_q[$];
        int cur;
        do_reset();
        pready = 1'b1;
        cur = 0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i << 8), DW'(32'hA000_0000 + i));
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) exp_q.push_back(i);
        for (int c = 0; c <= 16; c++) begin
            @(negedge pclk);
            if (c % 2 == 0 && c <= 14) begin
                cur = exp_q.pop_front();
                exp_v = '0; exp_v[cur] = 1'b1;
                n_checks++; if (req_ready_o !== exp_v) begin n_fail++; $display("FAIL rr_grant_c%0d: got %b expected %b", c, req_ready_o, exp_v); end
                rsp_q.push_back(cur);
            end
            if (c % 2 == 1) begin
                n_checks++; if ({psel, penable} !== 2'b10 || paddr !== AW'(cur << 8) || req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL rr_setup_c%0d: got %b/%h/%b expected 10/%h/0000", c, {psel, penable}, paddr, req_ready_o, AW'(cur << 8)); end
            end
            if (c % 2 == 0 && c >= 2) begin
                exp_v = '0; exp_v[rsp_q.pop_front()] = 1'b1;
                n_checks++; if ({psel, penable} !== 2'b11 || rsp_valid_o !== exp_v) begin n_fail++; $display("FAIL rr_access_c%0d: got %b/%b expected 11/%b", c, {psel, penable}, rsp_valid_o, exp_v); end
            end
            next_cycle();
        end
        req_valid_i = '0;
    endtask

    task automatic test_rotation();
        do_reset();
        pready = 1'b1;
        set_req(1, 1'b0, 32'h40, 32'h0);
        @(negedge pclk);
        n_checks++; if (req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL rot_first: got %b expected 0010", req_ready_o); end
        next_cycle();
        req_valid_i = '0;
        next_cycle();
        next_cycle();
        set_req(0, 1'b0, 32'h100, 32'h0);
        set_req(3, 1'b1, 32'h300, 32'h33);
        @(negedge pclk);
        n_checks++; if (req_ready_o !== 4'b1000) begin n_fail++; $display("FAIL rot_req3: got %b expected 1000", req_ready_o); end
        next_cycle();
        req_valid_i[3] = 1'b0;
        @(negedge pclk);
        n_checks++; if (paddr !== 32'h300 || req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL rot_setup3: got %h/%b expected 300/0000", paddr, req_ready_o); end
        next_cycle();
        @(negedge pclk);
        n_checks++; if (rsp_valid_o !== 4'b1000 || req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL rot_req0: got %b/%b expected 1000/0001", rsp_valid_o, req_ready_o); end
        next_cycle();
        req_valid_i = '0;
        @(negedge pclk);
        n_checks++; if ({psel, penable} !== 2'b10 || paddr !== 32'h100) begin n_fail++; $display("FAIL rot_setup0: got %b/%h expected 10/100", {psel, penable}, paddr); end
    endtask

    task automatic test_error();
        do_reset();
        pready  = 1'b1;
        pslverr = 1'b1;
        set_req(1, 1'b1, 32'h80, 32'h55);
        @(negedge pclk);
        n_checks++; if (req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL err_accept: got %b expected 0010", req_ready_o); end
        next_cycle();
        req_valid_i = '0;
        next_cycle();
        @(negedge pclk);
        n_checks++; if (rsp_valid_o !== 4'b0010 || rsp_err_o !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b/%b expected 0010/1", rsp_valid_o, rsp_err_o); end
        next_cycle();
        pslverr = 1'b0;
        prdata  = 32'hCAFE_F00D;
        set_req(0, 1'b0, 32'h84, 32'h0);
        next_cycle();
        req_valid_i = '0;
        next_cycle();
        @(negedge pclk);
        n_checks++; if (rsp_valid_o !== 4'b0001 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL err_clear: got %b/%b/%h expected 0001/0/cafef00d", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        pready = 1'b0;
        set_req(1, 1'b1, 32'hABC0, 32'h77);
        next_cycle();
        req_valid_i = '0;
        next_cycle();
        @(negedge pclk);
        n_checks++; if ({psel, penable} !== 2'b11) begin n_fail++; $display("FAIL mid_access: got %b expected 11", {psel, penable}); end
        presetn = 1'b0;
        pready  = 1'b1;
        #1;
        n_checks++; if ({psel, penable} !== 2'b00 || rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL mid_async: got %b/%b expected 00/0000", {psel, penable}, rsp_valid_o); end
        n_checks++; if (paddr !== '0 || pwrite !== 1'b0) begin n_fail++; $display("FAIL mid_payload: got %h/%b expected 0/0", paddr, pwrite); end
        @(posedge pclk);
        #1;
        n_checks++; if (rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL mid_no_rsp: got %b expected 0000", rsp_valid_o); end
        pready = 1'b0;
        set_req(0, 1'b0, 32'h10, 32'h0);
        set_req(2, 1'b0, 32'h20, 32'h0);
        presetn = 1'b1;
        @(negedge pclk);
        n_checks++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL mid_priority: got %b expected 0001", req_ready_o); end
        next_cycle();
        req_valid_i = '0;
    endtask

    // Randomized traffic: requesters arrive at random, completer inserts 0..3 wait states.
    task automatic test_random();
        bit             pend[N];
        logic           p_write[N];
        logic [AW-1:0]  p_addr[N];
        logic [DW-1:0]  p_wdata[N];
        int             m_last;
        bit             infl;
        int             cur_i;
        logic           cur_w;
        logic [AW-1:0]  cur_a;
        logic [DW-1:0]  cur_d;
        int             acc_cyc;
        int             done_cyc;
        int             cyc;
        int             win;
        int             n_done;
        bit             completing;
        logic [N-1:0]   exp_v;
        do_reset();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        m_last   = N - 1;
        infl     = 1'b0;
        cur_i    = 0;
        cur_w    = 1'b0;
        cur_a    = '0;
        cur_d    = '0;
        acc_cyc  = 0;
        done_cyc = 0;
        n_done   = 0;
        cyc      = 0;
        for (int step = 0; step < 1500; step++) begin
            completing = infl && (cyc == done_cyc);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && !(infl && cur_i == i && !completing) && $urandom_range(0, 3) == 0) begin
                    pend[i]    = 1'b1;
                    p_write[i] = 1'($urandom_range(0, 1));
                    p_addr[i]  = $urandom;
                    p_wdata[i] = $urandom;
                end
                req_valid_i[i] = pend[i];
                req_write_i[i] = pend[i] ? p_write[i] : 1'($urandom_range(0, 1));
                req_addr_i[i*AW +: AW]  = pend[i] ? p_addr[i] : $urandom;
                req_wdata_i[i*DW +: DW] = pend[i] ? p_wdata[i] : $urandom;
            end
            if (infl && cyc >= acc_cyc + 2) pready = completing;
            else pready = 1'($urandom_range(0, 1));
            prdata  = $urandom;
            pslverr = 1'($urandom_range(0, 1));
            @(negedge pclk);
            if (infl) begin
                n_checks++; if ({psel, penable} !== {1'b1, (cyc >= acc_cyc + 2)}) begin n_fail++; $display("FAIL rnd_phase_c%0d: got %b expected %b", cyc, {psel, penable}, {1'b1, (cyc >= acc_cyc + 2)}); end
                n_checks++; if (paddr !== cur_a || pwrite !== cur_w || pwdata !== cur_d || pstrb !== {(DW/8){cur_w}}) begin n_fail++; $display("FAIL rnd_bus_c%0d: got %h/%b/%h expected %h/%b/%h", cyc, paddr, pwrite, pwdata, cur_a, cur_w, cur_d); end
            end else begin
                n_checks++; if ({psel, penable} !== 2'b00) begin n_fail++; $display("FAIL rnd_idle_c%0d: got %b expected 00", cyc, {psel, penable}); end
            end
            exp_v = '0;
            if (completing) exp_v[cur_i] = 1'b1;
            n_checks++; if (rsp_valid_o !== exp_v) begin n_fail++; $display("FAIL rnd_rsp_valid_c%0d: got %b expected %b", cyc, rsp_valid_o, exp_v); end
            n_checks++; if (rsp_rdata_o !== ((completing && !cur_w) ? prdata : '0) || rsp_err_o !== (completing & pslverr)) begin n_fail++; $display("FAIL rnd_rsp_data_c%0d: got %h/%b expected %h/%b", cyc, rsp_rdata_o, rsp_err_o, (completing && !cur_w) ? prdata : '0, completing & pslverr); end
            win = -1;
            if (!infl || completing) begin
                for (int k = 1; k <= N; k++) begin
                    int cand;
                    cand = (m_last + k) % N;
                    if (win < 0 && pend[cand]) win = cand;
                end
            end
            exp_v = '0;
            if (win >= 0) exp_v[win] = 1'b1;
            n_checks++; if (req_ready_o !== exp_v) begin n_fail++; $display("FAIL rnd_grant_c%0d: got %b expected %b", cyc, req_ready_o, exp_v); end
            if (completing) begin
                infl = 1'b0;
                n_done++;
            end
            if (win >= 0) begin
                pend[win] = 1'b0;
                m_last    = win;
                infl      = 1'b1;
                cur_i     = win;
                cur_w     = p_write[win];
                cur_a     = p_addr[win];
                cur_d     = p_wdata[win];
                acc_cyc   = cyc;
                done_cyc  = cyc + 2 + int'($urandom_range(0, 3));
            end
            next_cycle();
            cyc++;
        end
        n_checks++; if (n_done < 100) begin n_fail++; $display("FAIL rnd_traffic: got %0d completions expected at least 100", n_done); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        clear_inputs();
        test_reset();
        test_single_write();
        test_wait_read();
        test_back_to_back();
        test_rotation();
        test_error();
        test_reset_mid_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
